rom_loader_spi_writer: RTL and testbench

- Sits inside hack_soc, directly upstream of the external ROM serial SRAM (23LC1024-compatible) on the rom_* pins.
- Accepts 16-bit Hack instruction words from the external loader handshake (rom_loader_*).
- Writes each accepted word into the ROM SRAM with an SPI-mode WRITE transaction, at sequential word addresses.
- While active it owns the ROM pins and holds the CPU/ROM fetch path off via rom_loader_busy.

---
 rtl/rom_loader_spi_writer.sv | 205 ++++++++++++++++++++
 tb/tb_rom_loader_spi_writer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader_spi_writer.sv
// Streams 16-bit loader words into a 23LC1024-style serial SRAM, one SPI WRITE frame per word.
// Holds the ROM pins and stalls the fetch path (busy) while a loading session is active.
module rom_loader_spi_writer #(
    parameter int SCK_DIV    = 1,
    parameter int ADDR_WIDTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rom_loader_load,
    input  logic        rom_loader_reset,
    input  logic [15:0] rom_loader_data,
    input  logic        rom_loader_valid,
    output logic        rom_loader_ack,
    output logic        rom_loader_load_received,
    output logic        rom_loader_busy,
    output logic        rom_cs_n,
    output logic        rom_sck,
    output logic        rom_sio_oe,
    output logic        rom_sio0_o,
    output logic        rom_sio1_o,
    output logic        rom_sio2_o,
    output logic        rom_sio3_o,
    input  logic        rom_sio1_i
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_WORD = 3'd1,
        CS_SETUP  = 3'd2,
        SHIFT     = 3'd3,
        CS_HOLD   = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam logic [3:0] DIV_LAST  = 4'(SCK_DIV - 1);
    localparam logic [6:0] HALF_LAST = 7'd95;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [47:0]             frame_q, frame_d;
    logic [3:0]              div_q, div_d;
    logic [6:0]              half_q, half_d;
    logic                    cs_n_q, cs_n_d;
    logic                    sck_q, sck_d;
    logic                    sio_oe_q, sio_oe_d;
    logic                    sio0_q, sio0_d;
    logic                    load_received_q, load_received_d;
    logic                    busy_q, busy_d;
    logic                    ack_s;
    logic [ADDR_WIDTH-1:0]   addr_sel_s;
    logic [23:0]             byte_addr_s;
    logic                    unused_s;

    // SO is never read back; it exists only so the pin mux is symmetric.
    assign unused_s = rom_sio1_i;

    // Next-state, frame shifter and registered pin values.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        frame_d         = frame_q;
        div_d           = div_q;
        half_d          = half_q;
        cs_n_d          = cs_n_q;
        sck_d           = sck_q;
        sio_oe_d        = sio_oe_q;
        sio0_d          = sio0_q;
        load_received_d = 1'b0;
        ack_s           = 1'b0;

        // A loader reset in the accept cycle sends that very word to address 0.
        if (rom_loader_reset) begin
            addr_sel_s = '0;
        end else begin
            addr_sel_s = addr_q;
        end
        byte_addr_s = 24'h000000;
        byte_addr_s[ADDR_WIDTH:1] = addr_sel_s;

        case (state_q)
            IDLE: begin
                if (rom_loader_reset) begin
                    addr_d = '0;
                end else begin
                    addr_d = addr_q;
                end
                if (rom_loader_load) begin
                    state_d = WAIT_WORD;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_WORD: begin
                if (rom_loader_reset) begin
                    addr_d = '0;
                end else begin
                    addr_d = addr_q;
                end
                if (!rom_loader_load) begin
                    state_d = IDLE;
                end else if (rom_loader_valid) begin
                    ack_s    = 1'b1;
                    frame_d  = {CMD_WRITE, byte_addr_s, rom_loader_data};
                    state_d  = CS_SETUP;
                    cs_n_d   = 1'b0;
                    sio_oe_d = 1'b1;
                    sck_d    = 1'b0;
                    sio0_d   = frame_d[47];
                end else begin
                    state_d = WAIT_WORD;
                end
            end
            CS_SETUP: begin
                state_d = SHIFT;
                sck_d   = 1'b1;
                div_d   = 4'd0;
                half_d  = 7'd0;
            end
            SHIFT: begin
                // 96 half-periods starting high: the SRAM samples on each rising edge,
                // and the next bit is presented as sck falls.
                if (div_q == DIV_LAST) begin
                    div_d = 4'd0;
                    if (half_q == HALF_LAST) begin
                        state_d = CS_HOLD;
                        sck_d   = 1'b0;
                    end else begin
                        half_d = half_q + 7'd1;
                        sck_d  = ~sck_q;
                        if (sck_q) begin
                            frame_d = {frame_q[46:0], 1'b0};
                            sio0_d  = frame_q[46];
                        end else begin
                            frame_d = frame_q;
                        end
                    end
                end else begin
                    div_d = div_q + 4'd1;
                end
            end
            CS_HOLD: begin
                state_d         = DONE;
                cs_n_d          = 1'b1;
                sio_oe_d        = 1'b0;
                sio0_d          = 1'b0;
                load_received_d = 1'b1;
            end
            DONE: begin
                addr_d = addr_q + ADDR_WIDTH'(1);
                if (rom_loader_load) begin
                    state_d = WAIT_WORD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            frame_q         <= 48'h0;
            div_q           <= 4'd0;
            half_q          <= 7'd0;
            cs_n_q          <= 1'b1;
            sck_q           <= 1'b0;
            sio_oe_q        <= 1'b0;
            sio0_q          <= 1'b0;
            load_received_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            frame_q         <= frame_d;
            div_q           <= div_d;
            half_q          <= half_d;
            cs_n_q          <= cs_n_d;
            sck_q           <= sck_d;
            sio_oe_q        <= sio_oe_d;
            sio0_q          <= sio0_d;
            load_received_q <= load_received_d;
            busy_q          <= busy_d;
        end
    end

    assign rom_loader_ack           = ack_s;
    assign rom_loader_load_received = load_received_q;
    assign rom_loader_busy          = busy_q;
    assign rom_cs_n                 = cs_n_q;
    assign rom_sck                  = sck_q;
    assign rom_sio_oe               = sio_oe_q;
    assign rom_sio0_o               = sio0_q;
    assign rom_sio1_o               = 1'b0;
    assign rom_sio2_o               = 1'b1;
    assign rom_sio3_o               = 1'b1;

endmodule

// File: tb/tb_rom_loader_spi_writer.sv
// Scoreboard bench: two writers (SCK_DIV=1/ADDR_WIDTH=16 and SCK_DIV=3/ADDR_WIDTH=2) feed a
// cycle-sampled SPI SRAM model; each load_received pops an expected word and checks the memory.
module tb_rom_loader_spi_writer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst, load, lreset, valid;
    logic [1:0][15:0] data;
    logic [1:0]       ack, lrx, busy, cs_n, sck, oe, s0, s1, s2, s3;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rom_loader_spi_writer #(.SCK_DIV(1), .ADDR_WIDTH(16)) u_dut0 (
        .clk(clk), .reset(rst[0]), .rom_loader_load(load[0]), .rom_loader_reset(lreset[0]),
        .rom_loader_data(data[0]), .rom_loader_valid(valid[0]), .rom_loader_ack(ack[0]),
        .rom_loader_load_received(lrx[0]), .rom_loader_busy(busy[0]), .rom_cs_n(cs_n[0]),
        .rom_sck(sck[0]), .rom_sio_oe(oe[0]), .rom_sio0_o(s0[0]), .rom_sio1_o(s1[0]),
        .rom_sio2_o(s2[0]), .rom_sio3_o(s3[0]), .rom_sio1_i(1'b0));

    rom_loader_spi_writer #(.SCK_DIV(3), .ADDR_WIDTH(2)) u_dut1 (
        .clk(clk), .reset(rst[1]), .rom_loader_load(load[1]), .rom_loader_reset(lreset[1]),
        .rom_loader_data(data[1]), .rom_loader_valid(valid[1]), .rom_loader_ack(ack[1]),
        .rom_loader_load_received(lrx[1]), .rom_loader_busy(busy[1]), .rom_cs_n(cs_n[1]),
        .rom_sck(sck[1]), .rom_sio_oe(oe[1]), .rom_sio0_o(s0[1]), .rom_sio1_o(s1[1]),
        .rom_sio2_o(s2[1]), .rom_sio3_o(s3[1]), .rom_sio1_i(1'b0));

    typedef struct {
        int          baddr;
        logic [15:0] word;
    } exp_t;

    exp_t        q0[$], q1[$];
    logic [7:0]  mem     [2][256];
    logic [7:0]  exp_img [2][256];
    int          n_cmp = 0, n_bad = 0;
    int          ack_cnt[2], lrx_cnt[2], ack_cyc[2];
    int          lo_run[2], hi_run[2], sck_hi[2], rises[2], frames[2], nb[2];
    logic [47:0] sh[2];
    logic [1:0]  p_cs, p_sck, p_s0, pin_bad;

    function automatic int sd_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int q_size(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present a word and wait (bounded) for its ack; optionally record the expected write.
    task automatic send_word(input int i, input logic [15:0] d, input int waddr, input bit hold,
                             input bit with_rst, input bit expect_wr, output int wc);
        exp_t e;
        data[i]   = d;
        valid[i]  = 1'b1;
        lreset[i] = with_rst;
        wc = 0;
        @(negedge clk);
        while (ack[i] !== 1'b1 && wc < 2000) begin
            @(negedge clk);
            wc++;
        end
        if (ack[i] !== 1'b1) begin
            chk("ack_timeout", 32'(ack[i]), 32'd1);
        end else if (expect_wr) begin
            e.baddr = 2 * waddr;
            e.word  = d;
            if (i == 0) q0.push_back(e); else q1.push_back(e);
            exp_img[i][8'(2 * waddr)]     = d[15:8];
            exp_img[i][8'(2 * waddr + 1)] = d[7:0];
        end
        @(posedge clk);
        #1;
        lreset[i] = 1'b0;
        if (!hold) valid[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int k;
        k = 0;
        while (q_size(i) != 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("drain_pending", 32'(q_size(i)), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input int i);
        chk("reset_outputs",
            32'({cs_n[i], sck[i], oe[i], s0[i], ack[i], lrx[i], busy[i], s1[i], s2[i], s3[i]}),
            32'b10_0000_0011);
    endtask

    // Monitor: SPI SRAM model, frame timing and scoreboard, all sampled on the falling clk edge.
    initial begin
        logic [7:0] a;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 256; b++) mem[i][b] = 8'h00;
            ack_cnt[i] = 0; lrx_cnt[i] = 0; ack_cyc[i] = 0; lo_run[i] = 0; hi_run[i] = 0;
            sck_hi[i] = 0; rises[i] = 0; frames[i] = 0; nb[i] = 0; sh[i] = 48'h0;
        end
        p_cs = 2'b11; p_sck = 2'b00; p_s0 = 2'b00; pin_bad = 2'b00;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst[i] !== 1'b0) begin
                    p_cs[i] = 1'b1; p_sck[i] = 1'b0; p_s0[i] = 1'b0; nb[i] = 0; hi_run[i] = 0;
                end else begin
                    if (s1[i] !== 1'b0 || s2[i] !== 1'b1 || s3[i] !== 1'b1) pin_bad[i] = 1'b1;
                    if (s0[i] !== p_s0[i] && sck[i] !== 1'b0) pin_bad[i] = 1'b1;
                    if (ack[i] === 1'b1) begin
                        ack_cnt[i]++;
                        ack_cyc[i] = cyc;
                    end
                    if (cs_n[i] === 1'b0) begin
                        if (p_cs[i]) begin
                            if (frames[i] > 0) chk("cs_high_gap_ge2", 32'(hi_run[i] >= 2), 32'd1);
                            lo_run[i] = 0; rises[i] = 0; nb[i] = 0; sh[i] = 48'h0;
                        end
                        lo_run[i]++;
                        if (sck[i] === 1'b1 && !p_sck[i]) begin
                            rises[i]++;
                            sck_hi[i] = 0;
                            if (oe[i] === 1'b1) begin
                                sh[i] = {sh[i][46:0], s0[i]};
                                nb[i]++;
                            end
                        end
                        if (sck[i] === 1'b1) sck_hi[i]++;
                        if (sck[i] === 1'b0 && p_sck[i]) chk("sck_high_len", 32'(sck_hi[i]), 32'(sd_of(i)));
                    end else begin
                        if (!p_cs[i]) begin
                            chk("cs_low_len", 32'(lo_run[i]), 32'(2 + 96 * sd_of(i)));
                            chk("sck_rises", 32'(rises[i]), 32'd48);
                            frames[i]++;
                            if (nb[i] == 48 && sh[i][47:40] == 8'h02) begin
                                a = sh[i][23:16];
                                mem[i][a]         = sh[i][15:8];
                                mem[i][a + 8'd1]  = sh[i][7:0];
                            end
                            hi_run[i] = 0;
                        end
                        hi_run[i]++;
                    end
                    if (lrx[i] === 1'b1) begin
                        lrx_cnt[i]++;
                        if (q_size(i) == 0) begin
                            chk("lrx_unexpected", 32'd1, 32'd0);
                        end else begin
                            if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
                            chk("ack_to_lrx_latency", 32'(cyc - ack_cyc[i]), 32'(3 + 96 * sd_of(i)));
                            a = 8'(e.baddr);
                            chk("sram_byte_hi", 32'(mem[i][a]), 32'(e.word[15:8]));
                            chk("sram_byte_lo", 32'(mem[i][a + 8'd1]), 32'(e.word[7:0]));
                        end
                    end
                    p_cs[i] = cs_n[i]; p_sck[i] = sck[i]; p_s0[i] = s0[i];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        int k;
        rst = 2'b11; load = 2'b00; lreset = 2'b00; valid = 2'b00; data = '0;
        for (int i = 0; i < 2; i++) for (int b = 0; b < 256; b++) exp_img[i][b] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset(0);
        check_reset(1);
        @(posedge clk);
        #1;
        rst = 2'b00;

        // Writer 0: single word, ack in the cycle valid is seen.
        load[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_word(0, 16'hABCD, 0, 1'b0, 1'b0, 1'b1, wc);
        chk("ack_same_cycle", 32'(wc), 32'd0);
        wait_done(0);

        // Address clear, then three back-to-back words with valid held.
        lreset[0] = 1'b1;
        @(posedge clk);
        #1;
        lreset[0] = 1'b0;
        send_word(0, 16'h0001, 0, 1'b1, 1'b0, 1'b1, wc);
        send_word(0, 16'h0002, 1, 1'b1, 1'b0, 1'b1, wc);
        send_word(0, 16'h0003, 2, 1'b0, 1'b0, 1'b1, wc);
        wait_done(0);
        chk("acks_after_burst", 32'(ack_cnt[0]), 32'd4);
        chk("lrx_after_burst", 32'(lrx_cnt[0]), 32'd4);

        // Loader reset together with valid: this word goes to address 0.
        send_word(0, 16'h1234, 0, 1'b0, 1'b1, 1'b1, wc);
        wait_done(0);

        // Reset 20 cycles into SHIFT aborts the frame; the next word lands at address 0.
        send_word(0, 16'h5555, 1, 1'b0, 1'b0, 1'b0, wc);
        repeat (21) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("abort_cs_n", 32'(cs_n[0]), 32'd1);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_sio_oe", 32'(oe[0]), 32'd0);
        chk("abort_sck", 32'(sck[0]), 32'd0);
        @(posedge clk);
        #1;
        send_word(0, 16'hBEEF, 0, 1'b0, 1'b0, 1'b1, wc);
        wait_done(0);
        chk("acks_total_w0", 32'(ack_cnt[0]), 32'd7);
        chk("lrx_total_w0", 32'(lrx_cnt[0]), 32'd6);

        // Writer 1: slow SCK and a 2-bit word address that wraps on the fifth word.
        load[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++) send_word(1, 16'hA000 + 16'(n), n, 1'b0, 1'b0, 1'b1, wc);
        send_word(1, 16'hA004, 0, 1'b0, 1'b0, 1'b1, wc);
        send_word(1, 16'hA005, 1, 1'b0, 1'b0, 1'b1, wc);
        repeat (50) @(posedge clk);
        #1;
        load[1] = 1'b0;
        k = 0;
        @(negedge clk);
        while (lrx[1] !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("lrx_after_load_drop", 32'(lrx[1]), 32'd1);
        chk("busy_at_lrx", 32'(busy[1]), 32'd1);
        @(negedge clk);
        chk("busy_falls_after_lrx", 32'(busy[1]), 32'd0);
        wait_done(1);
        chk("acks_total_w1", 32'(ack_cnt[1]), 32'd6);
        chk("lrx_total_w1", 32'(lrx_cnt[1]), 32'd6);
        chk("idle_cs_n_w1", 32'(cs_n[1]), 32'd1);

        for (int b = 0; b < 6; b++) chk("final_image_w0", 32'(mem[0][b]), 32'(exp_img[0][b]));
        for (int b = 0; b < 8; b++) chk("final_image_w1", 32'(mem[1][b]), 32'(exp_img[1][b]));
        chk("static_pins_w0", 32'(pin_bad[0]), 32'd0);
        chk("static_pins_w1", 32'(pin_bad[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
